// File: rtl/ttc3_security_monitor.sv
// Runtime security monitor for the 3TC root-of-trust: DUS write-once lock, Device ID
// integrity and per-channel KDF key zeroization / deadlock checks with sticky reporting.
module ttc3_security_monitor #(
  parameter int NUM_KEY_CH      = 2,
  parameter int KEY_WIDTH       = 256,
  parameter int DEVICE_ID_WIDTH = 128,
  parameter int ZEROIZE_WINDOW  = 5,
  parameter int BUSY_TIMEOUT    = 1000,
  parameter int CNT_WIDTH       = 8,
  localparam int VW             = 3 + 3 * NUM_KEY_CH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             dus_write_enable,
  input  logic                             dus_valid,
  input  logic [DEVICE_ID_WIDTH-1:0]       device_id,
  input  logic                             device_id_valid,
  input  logic [NUM_KEY_CH-1:0]            kdf_busy,
  input  logic [NUM_KEY_CH-1:0]            kdf_done,
  input  logic [NUM_KEY_CH*KEY_WIDTH-1:0]  derived_key,
  input  logic                             clear_valid,
  input  logic [VW-1:0]                    clear_mask,
  input  logic                             alert_ack,
  output logic [VW-1:0]                    viol_status,
  output logic                             alert_valid,
  output logic [CNT_WIDTH-1:0]             viol_count,
  output logic [7:0]                       first_viol_idx,
  output logic                             lockdown
);

  localparam int MAXV = (BUSY_TIMEOUT > ZEROIZE_WINDOW) ? BUSY_TIMEOUT : ZEROIZE_WINDOW;
  localparam int CW   = $clog2(MAXV) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ZWAIT} state_t;

  logic                       r_lock;
  logic                       r_id_cap;
  logic [DEVICE_ID_WIDTH-1:0] r_id;
  logic [VW-1:0]              r_status;
  logic                       r_alert;
  logic [CNT_WIDTH-1:0]       r_count;
  logic [7:0]                 r_first_idx;
  logic                       r_lockdown;

  logic [VW-1:0]              w_new;
  logic                       w_any_new;
  logic [VW-1:0]              w_clr;
  logic [7:0]                 w_low_idx;

  // The lock is the registered value, so a write in the cycle the lock arms is legal.
  assign w_new[0] = dus_write_enable & r_lock;
  assign w_new[1] = device_id_valid & r_id_cap & (device_id != r_id);
  assign w_new[2] = device_id_valid & (device_id == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEY_CH; gi++) begin : g_ch
      state_t        r_state;
      state_t        w_state_next;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_next;
      logic          w_key_nz;
      logic          w_zero_viol;
      logic          w_win_viol;
      logic          w_to_viol;

      assign w_key_nz = |derived_key[gi*KEY_WIDTH +: KEY_WIDTH];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_zero_viol  = 1'b0;
        w_win_viol   = 1'b0;
        w_to_viol    = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (kdf_done[gi]) begin
              w_state_next = ST_ZWAIT;
              w_cnt_next   = CW'(ZEROIZE_WINDOW);
            end else if (kdf_busy[gi]) begin
              w_state_next = ST_BUSY;
              w_cnt_next   = CW'(1);
            end else if (w_key_nz) begin
              w_win_viol = 1'b1;
            end
          end
          ST_BUSY: begin
            if (kdf_done[gi]) begin
              w_state_next = ST_ZWAIT;
              w_cnt_next   = CW'(ZEROIZE_WINDOW);
            end else if (!kdf_busy[gi]) begin
              w_state_next = ST_IDLE;
            end else if (r_cnt != CW'(BUSY_TIMEOUT)) begin
              // Counter parks at the timeout so the deadlock is reported only once.
              w_cnt_next = r_cnt + CW'(1);
              w_to_viol  = (r_cnt + CW'(1)) == CW'(BUSY_TIMEOUT);
            end
          end
          ST_ZWAIT: begin
            if (!w_key_nz) begin
              w_state_next = ST_IDLE;
            end else if (kdf_busy[gi]) begin
              w_state_next = ST_BUSY;
              w_cnt_next   = CW'(1);
            end else if (r_cnt == CW'(1)) begin
              w_zero_viol  = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_cnt_next = r_cnt - CW'(1);
            end
          end
          default: begin
            w_state_next = ST_IDLE;
          end
        endcase
      end

      assign w_new[3+3*gi] = w_zero_viol;
      assign w_new[4+3*gi] = w_win_viol;
      assign w_new[5+3*gi] = w_to_viol;
    end
  endgenerate

  assign w_any_new = |w_new;
  assign w_clr     = clear_valid ? clear_mask : '0;

  always_comb begin
    w_low_idx = '0;
    for (int i = VW - 1; i >= 0; i--) begin
      if (w_new[i]) w_low_idx = 8'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock      <= 1'b0;
      r_id_cap    <= 1'b0;
      r_id        <= '0;
      r_status    <= '0;
      r_alert     <= 1'b0;
      r_count     <= '0;
      r_first_idx <= '0;
      r_lockdown  <= 1'b0;
    end else begin
      if (dus_valid) r_lock <= 1'b1;
      if (device_id_valid && !r_id_cap) begin
        r_id_cap <= 1'b1;
        r_id     <= device_id;
      end
      // New violations are OR'd in after the clear so they always win.
      r_status <= (r_status & ~w_clr) | w_new;
      if (w_any_new) begin
        r_alert    <= 1'b1;
        r_lockdown <= 1'b1;
        if (r_count != '1) r_count <= r_count + CNT_WIDTH'(1);
        if (r_count == '0) r_first_idx <= w_low_idx;
      end else if (alert_ack) begin
        r_alert <= 1'b0;
      end
    end
  end

  assign viol_status    = r_status;
  assign alert_valid    = r_alert;
  assign viol_count     = r_count;
  assign first_viol_idx = r_first_idx;
  assign lockdown       = r_lockdown;

endmodule
